// File: rtl/bubble_page_streamer_if.sv
// rtl/bubble_page_streamer_if.sv - loader and output-pin signal bundle for bubble_page_streamer
// master = loader/sequencer side, slave = the streamer itself.
interface bubble_page_streamer_if #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [CHANNELS-1:0]   wr_data;
  logic                  wr_commit;
  logic                  bank_ready;
  logic                  page_start;
  logic                  shift_strobe;
  logic [CHANNELS-1:0]   bubble_out;
  logic                  busy;
  logic                  page_done;
  logic                  underrun;

  modport master (
    output wr_enable, wr_address, wr_data, wr_commit, page_start, shift_strobe,
    input  bank_ready, bubble_out, busy, page_done, underrun
  );

  modport slave (
    input  wr_enable, wr_address, wr_data, wr_commit, page_start, shift_strobe,
    output bank_ready, bubble_out, busy, page_done, underrun
  );
endinterface

// File: rtl/bubble_page_streamer.sv
// rtl/bubble_page_streamer.sv - ping-pong page buffer streaming CHANNELS bubble lines
// Loader fills the back bank; page_start swaps it to the front and shifts it out.
module bubble_page_streamer #(
  parameter int   CHANNELS      = 2,
  parameter int   ADDR_WIDTH    = 10,
  parameter int   PAGE_LENGTH   = 584,
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter bit   OUTPUT_INVERT = 1'b0
) (
  input  logic                  master_clock,
  input  logic                  reset,
  bubble_page_streamer_if.slave bus
);
  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   PAGE_LEN  = (ADDR_WIDTH + 1)'(PAGE_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(PAGE_LENGTH - 1);
  localparam logic [CHANNELS-1:0]   IDLE_WORD = {CHANNELS{IDLE_LEVEL}};
  localparam logic [CHANNELS-1:0]   INV_MASK  = {CHANNELS{OUTPUT_INVERT}};

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                state;
  logic                  front_sel;
  logic                  back_full;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CHANNELS-1:0]   bubble_q;
  logic                  page_done_q;
  logic                  underrun_q;
  logic                  wr_ok;

  // Bank select is the MSB of the word address: {bank, offset}.
  logic [CHANNELS-1:0] bank_mem [0:2*DEPTH-1];

  assign wr_ok = bus.wr_enable && !back_full && ({1'b0, bus.wr_address} < PAGE_LEN);

  // Uses the pre-swap front_sel, so a write coinciding with a swap lands in the new front.
  always_ff @(posedge master_clock) begin
    if (wr_ok)
      bank_mem[{~front_sel, bus.wr_address}] <= bus.wr_data;
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state       <= S_IDLE;
      front_sel   <= 1'b0;
      back_full   <= 1'b0;
      rd_ptr      <= '0;
      bubble_q    <= IDLE_WORD;
      page_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      page_done_q <= 1'b0;
      if (bus.wr_commit && !back_full)
        back_full <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.shift_strobe)
            bubble_q <= IDLE_WORD;
          if (bus.page_start) begin
            if (back_full) begin
              front_sel <= ~front_sel;
              back_full <= 1'b0;
              rd_ptr    <= '0;
              state     <= S_STREAM;
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (bus.shift_strobe) begin
            bubble_q <= bank_mem[{front_sel, rd_ptr}] ^ INV_MASK;
            if (rd_ptr == LAST_PTR) begin
              page_done_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.bubble_out = bubble_q;
  assign bus.busy       = (state == S_STREAM);
  assign bus.bank_ready = !back_full;
  assign bus.page_done  = page_done_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_bubble_page_streamer.sv
// tb/tb_bubble_page_streamer.sv - directed self-checking bench for bubble_page_streamer
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bubble_page_streamer;
  localparam int PL = 584;

  logic master_clock = 1'b0;
  logic reset        = 1'b1;
  int   tests        = 0;
  int   fails        = 0;

  bubble_page_streamer_if #(.CHANNELS(2), .ADDR_WIDTH(10)) bus ();

  bubble_page_streamer #(
    .CHANNELS(2), .ADDR_WIDTH(10), .PAGE_LENGTH(PL), .IDLE_LEVEL(1'b1), .OUTPUT_INVERT(1'b0)
  ) dut (
    .master_clock(master_clock),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 master_clock = ~master_clock;

  function automatic logic [1:0] pat(input int sel, input int a);
    case (sel)
      0:       pat = (a % 2 == 1) ? 2'b10 : 2'b01;
      1:       pat = 2'((a * 3 + 1) % 4);
      2:       pat = 2'((a / 2) % 4);
      default: pat = 2'(((a * 5) / 4) % 4);
    endcase
  endfunction

  task automatic tick();
    @(posedge master_clock);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic write_page(input int sel);
    for (int a = 0; a < PL; a++) begin
      bus.wr_enable  = 1'b1;
      bus.wr_address = 10'(a);
      bus.wr_data    = pat(sel, a);
      tick();
    end
    bus.wr_enable = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
    chk("bank_ready_after_commit", 0, 32'(bus.bank_ready), 32'd0);
  endtask

  task automatic start_page();
    bus.page_start = 1'b1;
    tick();
    bus.page_start = 1'b0;
    chk("busy_after_start", 0, 32'(bus.busy), 32'd1);
    chk("bank_ready_after_start", 0, 32'(bus.bank_ready), 32'd1);
  endtask

  // Strobe every other cycle; with load_b, page B (pattern 1) is written and committed meanwhile.
  task automatic stream_page(input int sel, input bit load_b);
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < PL; i++) begin
      bus.shift_strobe = 1'b1;
      if (load_b && 2 * i < PL) begin
        bus.wr_enable = 1'b1; bus.wr_address = 10'(2 * i); bus.wr_data = pat(1, 2 * i);
      end
      tick();
      bus.shift_strobe = 1'b0;
      bus.wr_enable    = 1'b0;
      if (bus.page_done) done_cnt++;
      chk("stream_bit", i, 32'(bus.bubble_out), 32'(pat(sel, i)));
      chk("busy_during", i, 32'(bus.busy), (i == PL - 1) ? 32'd0 : 32'd1);

      if (load_b) begin
        if (2 * i + 1 < PL) begin
          bus.wr_enable = 1'b1; bus.wr_address = 10'(2 * i + 1); bus.wr_data = pat(1, 2 * i + 1);
        end else if (i == PL / 2) begin
          bus.wr_commit = 1'b1;
        end else begin
          bus.wr_enable = 1'b1; bus.wr_address = 10'((i * 7) % PL); bus.wr_data = ~pat(1, (i * 7) % PL);
        end
      end
      tick();
      bus.wr_enable = 1'b0;
      bus.wr_commit = 1'b0;
      if (bus.page_done) done_cnt++;
      chk("hold_bit", i, 32'(bus.bubble_out), 32'(pat(sel, i)));
    end
    chk("page_done_count", 0, 32'(done_cnt), 32'd1);
    bus.shift_strobe = 1'b1;
    tick();
    bus.shift_strobe = 1'b0;
    chk("idle_after_page", 0, 32'(bus.bubble_out), 32'h3);
  endtask

  initial begin
    bus.wr_enable    = 1'b0;
    bus.wr_address   = '0;
    bus.wr_data      = '0;
    bus.wr_commit    = 1'b0;
    bus.page_start   = 1'b0;
    bus.shift_strobe = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_bubble_out", 0, 32'(bus.bubble_out), 32'h3);
    chk("rst_bank_ready", 0, 32'(bus.bank_ready), 32'd1);
    chk("rst_busy", 0, 32'(bus.busy), 32'd0);
    chk("rst_page_done", 0, 32'(bus.page_done), 32'd0);
    chk("rst_underrun", 0, 32'(bus.underrun), 32'd0);

    // Single page, alternating pattern
    write_page(0);
    commit();
    start_page();
    chk("bubble_before_strobe", 0, 32'(bus.bubble_out), 32'h3);
    stream_page(0, 1'b0);

    // Underrun on empty back bank
    bus.page_start = 1'b1;
    tick();
    bus.page_start = 1'b0;
    chk("underrun_set", 0, 32'(bus.underrun), 32'd1);
    chk("underrun_busy", 0, 32'(bus.busy), 32'd0);
    chk("underrun_bubble", 0, 32'(bus.bubble_out), 32'h3);

    // Stream A while loading and committing B, then stream B
    write_page(0);
    commit();
    start_page();
    stream_page(0, 1'b1);
    chk("b_committed", 0, 32'(bus.bank_ready), 32'd0);
    start_page();
    stream_page(1, 1'b0);

    // Reset part way into a page
    write_page(2);
    commit();
    start_page();
    for (int i = 0; i < 100; i++) begin
      bus.shift_strobe = 1'b1;
      tick();
      bus.shift_strobe = 1'b0;
      tick();
    end
    chk("pre_reset_bit", 99, 32'(bus.bubble_out), 32'(pat(2, 99)));
    bus.shift_strobe = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.shift_strobe = 1'b0;
    chk("midrst_bubble", 0, 32'(bus.bubble_out), 32'h3);
    chk("midrst_busy", 0, 32'(bus.busy), 32'd0);
    chk("midrst_page_done", 0, 32'(bus.page_done), 32'd0);
    chk("midrst_bank_ready", 0, 32'(bus.bank_ready), 32'd1);
    chk("midrst_underrun", 0, 32'(bus.underrun), 32'd0);
    write_page(3);
    commit();
    start_page();
    stream_page(3, 1'b0);

    // Same-cycle page_start and commit on an empty back bank
    chk("pre_same_underrun", 0, 32'(bus.underrun), 32'd0);
    bus.page_start = 1'b1;
    bus.wr_commit  = 1'b1;
    tick();
    bus.page_start = 1'b0;
    bus.wr_commit  = 1'b0;
    chk("same_underrun", 0, 32'(bus.underrun), 32'd1);
    chk("same_bank_ready", 0, 32'(bus.bank_ready), 32'd0);
    chk("same_busy", 0, 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
